// File: rtl/mw_pipe_reg.sv
// M->W pipeline register: latches the M-stage result bundle and presents the W-stage bundle
// Latency: exactly one clock from M inputs to W outputs; all W outputs are plain flops
// Backpressure: stall holds every W register; flush loads a bubble and overrides stall
// Optional feature macro: MW_RETIRE_CNT_EN adds the W_retire_cnt port and its 32-bit counter.
module mw_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              M_valid,
  input  logic [31:0]       M_PC,
  input  logic [4:0]        M_A3,
  input  logic              M_RegWrite,
  input  logic [TNEW_W-1:0] M_Tnew,
  input  logic [1:0]        M_WDSel,
  input  logic [31:0]       M_ALUOut,
  input  logic [31:0]       M_DMOut,
  output logic              W_valid,
  output logic [31:0]       W_PC,
  output logic [4:0]        W_A3,
  output logic              W_RegWrite,
  output logic [TNEW_W-1:0] W_Tnew,
  output logic [31:0]       W_WD
`ifdef MW_RETIRE_CNT_EN
  ,
  output logic [31:0]       W_retire_cnt
`endif
);

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_DM  = 2'b01;
  localparam logic [1:0] WDSEL_PC8 = 2'b10;

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [4:0]        r_a3;
  logic              r_regwrite;
  logic [TNEW_W-1:0] r_tnew;
  logic [31:0]       r_wd;

  logic [31:0]       w_pc_plus8;
  logic [31:0]       w_wd_next;
  logic [TNEW_W-1:0] w_tnew_next;
  logic              w_regwrite_next;
  logic              w_load;

  assign w_pc_plus8 = M_PC + 32'd8;
  assign w_load     = !flush && !stall;

  // Writeback-data select resolved before the flop; the reserved code falls back to ALU result.
  always_comb begin
    w_wd_next = M_ALUOut;
    case (M_WDSel)
      WDSEL_ALU: w_wd_next = M_ALUOut;
      WDSEL_DM:  w_wd_next = M_DMOut;
      WDSEL_PC8: w_wd_next = w_pc_plus8;
      default:   w_wd_next = M_ALUOut;
    endcase
  end

  // Tnew counts down by one per stage and saturates at zero so it can never wrap high.
  always_comb begin
    w_tnew_next = '0;
    if (M_Tnew != '0) begin
      w_tnew_next = M_Tnew - TNEW_W'(1);
    end
  end

  // Bubbles and writes to $zero never raise the write enable, so forwarding cannot match them.
  assign w_regwrite_next = M_valid && M_RegWrite && (M_A3 != 5'd0);

  // W-stage bundle: flush loads a bubble, stall holds, otherwise capture the M bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_a3       <= 5'd0;
      r_regwrite <= 1'b0;
      r_tnew     <= '0;
      r_wd       <= 32'd0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_a3       <= 5'd0;
      r_regwrite <= 1'b0;
      r_tnew     <= '0;
      r_wd       <= 32'd0;
    end else if (!stall) begin
      r_valid    <= M_valid;
      r_pc       <= M_PC;
      r_a3       <= M_A3;
      r_regwrite <= w_regwrite_next;
      r_tnew     <= w_tnew_next;
      r_wd       <= w_wd_next;
    end
  end

  assign W_valid    = r_valid;
  assign W_PC       = r_pc;
  assign W_A3       = r_a3;
  assign W_RegWrite = r_regwrite;
  assign W_Tnew     = r_tnew;
  assign W_WD       = r_wd;

`ifdef MW_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count only real instructions that actually advance into W; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 32'd0;
    end else if (w_load && M_valid) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign W_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Bench for mw_pipe_reg: a reference model of the W-stage bundle checked every cycle,
// plus literal expectations for the reset, load, $zero/invalid, PC+8 wrap, stall/flush and counter cases.
// Counter checks exist only when MW_RETIRE_CNT_EN is defined.
module tb_mw_pipe_reg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        M_valid;
  logic [31:0] M_PC;
  logic [4:0]  M_A3;
  logic        M_RegWrite;
  logic [1:0]  M_Tnew;
  logic [1:0]  M_WDSel;
  logic [31:0] M_ALUOut;
  logic [31:0] M_DMOut;
  logic        W_valid;
  logic [31:0] W_PC;
  logic [4:0]  W_A3;
  logic        W_RegWrite;
  logic [1:0]  W_Tnew;
  logic [31:0] W_WD;
`ifdef MW_RETIRE_CNT_EN
  logic [31:0] W_retire_cnt;
`endif

  mw_pipe_reg #(.RESET_PC(RESET_PC), .TNEW_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .M_valid    (M_valid),
    .M_PC       (M_PC),
    .M_A3       (M_A3),
    .M_RegWrite (M_RegWrite),
    .M_Tnew     (M_Tnew),
    .M_WDSel    (M_WDSel),
    .M_ALUOut   (M_ALUOut),
    .M_DMOut    (M_DMOut),
    .W_valid    (W_valid),
    .W_PC       (W_PC),
    .W_A3       (W_A3),
    .W_RegWrite (W_RegWrite),
    .W_Tnew     (W_Tnew),
    .W_WD       (W_WD)
`ifdef MW_RETIRE_CNT_EN
    ,
    .W_retire_cnt (W_retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what W must hold, derived from the architectural rules.
  bit          e_valid;
  logic [31:0] e_pc;
  logic [4:0]  e_a3;
  bit          e_rw;
  int          e_tnew;
  logic [31:0] e_wd;
  logic [31:0] e_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid = 0; e_pc = RESET_PC; e_a3 = 0; e_rw = 0; e_tnew = 0; e_wd = 0; e_cnt = 0;
    end else if (flush) begin
      e_valid = 0; e_pc = RESET_PC; e_a3 = 0; e_rw = 0; e_tnew = 0; e_wd = 0;
    end else if (!stall) begin
      e_valid = M_valid;
      e_pc    = M_PC;
      e_a3    = M_A3;
      e_rw    = M_valid && M_RegWrite && (M_A3 != 0);
      e_tnew  = (int'(M_Tnew) > 0) ? int'(M_Tnew) - 1 : 0;
      if (M_WDSel == 2'd1)      e_wd = M_DMOut;
      else if (M_WDSel == 2'd2) e_wd = M_PC + 32'd8;
      else                      e_wd = M_ALUOut;
      if (M_valid) e_cnt = e_cnt + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", 32'(W_valid), 32'(e_valid));
      chk("cyc_pc",    W_PC,         e_pc);
      chk("cyc_a3",    32'(W_A3),    32'(e_a3));
      chk("cyc_rw",    32'(W_RegWrite), 32'(e_rw));
      chk("cyc_tnew",  32'(W_Tnew),  32'(e_tnew));
      chk("cyc_wd",    W_WD,         e_wd);
`ifdef MW_RETIRE_CNT_EN
      chk("cyc_cnt",   W_retire_cnt, e_cnt);
`endif
    end
  end

  // Drive one M bundle at the falling edge, then wait for the next falling edge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [4:0] a3, input bit rw,
                      input logic [1:0] tn, input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] dm, input bit st, input bit fl);
    M_valid = v; M_PC = pc; M_A3 = a3; M_RegWrite = rw; M_Tnew = tn; M_WDSel = sel;
    M_ALUOut = alu; M_DMOut = dm; stall = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; stall = 0; flush = 0;
    M_valid = 0; M_PC = 0; M_A3 = 0; M_RegWrite = 0; M_Tnew = 0; M_WDSel = 0;
    M_ALUOut = 0; M_DMOut = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc",    W_PC, RESET_PC);
    chk("rst_valid", 32'(W_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Load a DM-sourced write with Tnew=2
    step(1, 32'h0000_3010, 5'd8, 1, 2'd2, 2'b01, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0);
    chk("load_a3",   32'(W_A3), 32'd8);
    chk("load_rw",   32'(W_RegWrite), 32'd1);
    chk("load_tnew", 32'(W_Tnew), 32'd1);
    chk("load_wd",   W_WD, 32'hDEAD_BEEF);
    chk("load_pc",   W_PC, 32'h0000_3010);

    // Write to $zero, then an invalid instruction
    step(1, 32'h0000_3014, 5'd0, 1, 2'd1, 2'b00, 32'h0000_0055, 32'h0, 0, 0);
    chk("zero_rw", 32'(W_RegWrite), 32'd0);
    chk("zero_wd", W_WD, 32'h0000_0055);
    step(0, 32'h0000_3018, 5'd9, 1, 2'd1, 2'b00, 32'h0000_0066, 32'h0, 0, 0);
    chk("inv_rw",    32'(W_RegWrite), 32'd0);
    chk("inv_valid", 32'(W_valid), 32'd0);
    chk("inv_a3",    32'(W_A3), 32'd9);

    // PC+8 with 32-bit wrap, Tnew already zero
    step(1, 32'hFFFF_FFFC, 5'd31, 1, 2'd0, 2'b10, 32'h1234_5678, 32'h0, 0, 0);
    chk("pc8_wd",   W_WD, 32'h0000_0004);
    chk("pc8_tnew", 32'(W_Tnew), 32'd0);
    // Reserved select behaves as ALU
    step(1, 32'h0000_3020, 5'd3, 1, 2'd3, 2'b11, 32'hCAFE_F00D, 32'hBAD0_BAD0, 0, 0);
    chk("sel11_wd",  W_WD, 32'hCAFE_F00D);
    chk("sel11_tnew", 32'(W_Tnew), 32'd2);

    // Stall for three cycles with changing M inputs: W must hold
    step(1, 32'h0000_4000, 5'd12, 1, 2'd1, 2'b00, 32'hA5A5_0001, 32'h0, 1, 0);
    step(1, 32'h0000_4004, 5'd13, 0, 2'd2, 2'b01, 32'hA5A5_0002, 32'h7, 1, 0);
    step(0, 32'h0000_4008, 5'd14, 1, 2'd0, 2'b10, 32'hA5A5_0003, 32'h8, 1, 0);
    chk("stall_wd", W_WD, 32'hCAFE_F00D);
    chk("stall_a3", 32'(W_A3), 32'd3);
    chk("stall_pc", W_PC, 32'h0000_3020);
    // Stall and flush together: bubble
    step(1, 32'h0000_400C, 5'd15, 1, 2'd2, 2'b00, 32'hA5A5_0004, 32'h0, 1, 1);
    chk("flush_valid", 32'(W_valid), 32'd0);
    chk("flush_pc",    W_PC, RESET_PC);
    chk("flush_wd",    W_WD, 32'd0);
    chk("flush_rw",    32'(W_RegWrite), 32'd0);

    // Reset while stalled with a live bundle: clears without a clock edge
    step(1, 32'h0000_5000, 5'd20, 1, 2'd2, 2'b00, 32'h0BAD_CAFE, 32'h0, 0, 0);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_pc",   W_PC, RESET_PC);
    chk("amid_wd",   W_WD, 32'd0);
    chk("amid_a3",   32'(W_A3), 32'd0);
    chk("amid_tnew", 32'(W_Tnew), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;

`ifdef MW_RETIRE_CNT_EN
    chk("cnt_rst", W_retire_cnt, 32'd0);
    for (int i = 0; i < 5; i++)
      step(1, 32'h0000_6000 + 32'(4 * i), 5'(i + 1), 1, 2'd1, 2'b00, 32'(i), 32'h0, 0, 0);
    step(1, 32'h0000_6100, 5'd7, 1, 2'd1, 2'b00, 32'h1, 32'h0, 1, 0);
    step(1, 32'h0000_6104, 5'd7, 1, 2'd1, 2'b00, 32'h2, 32'h0, 1, 0);
    step(1, 32'h0000_6108, 5'd7, 1, 2'd1, 2'b00, 32'h3, 32'h0, 0, 1);
    step(0, 32'h0000_610C, 5'd7, 1, 2'd1, 2'b00, 32'h4, 32'h0, 0, 0);
    chk("cnt_five", W_retire_cnt, 32'd5);
    #2;
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    e_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retire_cnt;
    step(1, 32'h0000_6200, 5'd4, 1, 2'd0, 2'b00, 32'h9, 32'h0, 0, 0);
    chk("cnt_wrap", W_retire_cnt, 32'd0);
`endif

    // Mixed directed vectors
    step(1, 32'h0000_7000, 5'd1,  1, 2'd2, 2'b10, 32'h0, 32'h0, 0, 0);
    step(1, 32'h0000_7004, 5'd2,  0, 2'd1, 2'b01, 32'h0, 32'h8000_0001, 0, 0);
    step(1, 32'h0000_7008, 5'd30, 1, 2'd0, 2'b00, 32'h7FFF_FFFF, 32'h0, 0, 1);
    step(1, 32'h0000_700C, 5'd17, 1, 2'd1, 2'b01, 32'h0, 32'h1357_9BDF, 0, 0);
    chk("vec_wd", W_WD, 32'h1357_9BDF);
    step(0, 32'h0, 5'd0, 0, 2'd0, 2'b00, 32'h0, 32'h0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
